mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 4:1 mux channel.
- Four requesters compete for one output path. The block drives the mux select and a one-hot grant.
- It counts accepted transfers per grant and forces release after a burst limit, so no requester can starve the others.
- It sits beside the mux4to1 tree and feeds its `sel` input directly.

---
 rtl/mux_rr_arbiter_if.sv | 34 +++
 rtl/mux_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - handshake bundle between requesters, arbiter and mux4to1 select
// The optional lock input exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic             busy;
    logic             xfer;
    logic [CNT_W-1:0] owner_cnt;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;

    modport master (
        output req, out_ready, lock,
        input  sel, gnt, busy, xfer, owner_cnt
    );
    modport slave (
        input  req, out_ready, lock,
        output sel, gnt, busy, xfer, owner_cnt
    );
`else
    modport master (
        output req, out_ready,
        input  sel, gnt, busy, xfer, owner_cnt
    );
    modport slave (
        input  req, out_ready,
        output sel, gnt, busy, xfer, owner_cnt
    );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with burst limit driving a 4:1 mux select
// Optional burst-limit lock is enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_rr_arbiter_if.slave       bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic             LIMIT_ON  = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;
    logic             lock_on;
    logic             rel_a, rel_b;
    logic [1:0]       scan_base;
    logic [1:0]       win;

`ifdef MUX_ARB_LOCK_EN
    assign lock_on = bus.lock;
`else
    assign lock_on = 1'b0;
`endif

    // First set bit at or after base, wrapping upward.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        pick = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign xfer      = (|(gnt_q & bus.req)) & bus.out_ready;
    assign scan_base = (state_q == IDLE) ? ptr_q + 2'd1 : sel_q + 2'd1;
    assign win       = pick(bus.req, scan_base);
    assign rel_a     = (state_q == GRANT) && !bus.req[sel_q];
    assign rel_b     = (state_q == GRANT) && xfer && LIMIT_ON && !lock_on && (cnt_q >= HOLD_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_a || rel_b) begin
                    // The owner sits last in the scan, so a forced release only re-grants it when alone.
                    ptr_d = sel_q;
                    cnt_d = '0;
                    if (|bus.req) begin
                        gnt_d = 4'b0001 << win;
                        sel_d = win;
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end else if (xfer && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = |gnt_q;
    assign bus.xfer      = xfer;
    assign bus.owner_cnt = cnt_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    mux_rr_arbiter_if #(.CNT_W(8)) bus ();

    mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_owner(input string tag, input int g);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << g));
        chk({tag, "_sel"}, 32'(bus.sel), 32'(g));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock      = 1'b0;
`endif
        tick();
        chk("rst_gnt",  32'(bus.gnt), 32'h0);
        chk("rst_sel",  32'(bus.sel), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_cnt",  32'(bus.owner_cnt), 32'h0);
        chk("rst_xfer", 32'(bus.xfer), 32'h0);

        // single requester: grant latency, forced release and immediate re-grant
        rst_n = 1'b1;
        bus.req = 4'b0001;
        bus.out_ready = 1'b1;
        #1;
        chk("lat_pre_gnt", 32'(bus.gnt), 32'h0);
        tick();
        chk_owner("lat", 0);
        chk("lat_xfer", 32'(bus.xfer), 32'h1);
        for (int k = 0; k < 7; k++) tick();
        chk("solo_cnt7", 32'(bus.owner_cnt), 32'd7);
        tick();
        chk_owner("solo_regrant", 0);
        chk("solo_cnt0", 32'(bus.owner_cnt), 32'd0);

        // all requesting: 0,1,2,3,0 with 8 transfers each, no idle gap
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            chk_owner("rr", i % 4);
            if (i < 4) begin
                for (int k = 0; k < 8; k++) begin
                    chk("rr_cnt", 32'(bus.owner_cnt), 32'(k));
                    chk("rr_busy", 32'(bus.busy), 32'h1);
                    tick();
                end
            end
        end

        // owner drops: go idle, then owner 2 drops after 3 transfers
        bus.req = 4'b0000;
        tick();
        chk("idle_gnt", 32'(bus.gnt), 32'h0);
        chk("idle_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b0100;
        tick();
        chk_owner("own2", 2);
        bus.req = 4'b0101;
        for (int k = 0; k < 3; k++) tick();
        chk("own2_cnt3", 32'(bus.owner_cnt), 32'd3);
        bus.req = 4'b0001;
        tick();
        chk_owner("drop2", 0);
        chk("drop2_cnt", 32'(bus.owner_cnt), 32'd0);
        bus.req = 4'b1001;
        for (int k = 0; k < 8; k++) tick();
        chk_owner("contest", 3);

        // idle keeps sel at last owner
        bus.req = 4'b0000;
        tick();
        chk("idle3_gnt", 32'(bus.gnt), 32'h0);
        chk("idle3_sel", 32'(bus.sel), 32'd3);
        tick();
        chk("idle3_sel_hold", 32'(bus.sel), 32'd3);

        // reset mid-grant
        bus.req = 4'b1000;
        tick();
        chk_owner("pre_rst", 3);
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_cnt", 32'(bus.owner_cnt), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",  32'(bus.gnt), 32'h0);
        chk("mid_rst_sel",  32'(bus.sel), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_cnt",  32'(bus.owner_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_busy", 32'(bus.busy), 32'h0);
        tick();
        chk_owner("post_rst", 3);

        // back-pressure: grant held, nothing counted
        bus.req = 4'b0010;
        tick();
        chk_owner("bp", 1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_gnt",  32'(bus.gnt), 32'h2);
            chk("bp_cnt",  32'(bus.owner_cnt), 32'h0);
            chk("bp_xfer", 32'(bus.xfer), 32'h0);
        end
        bus.out_ready = 1'b1;

`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b1;
        bus.req  = 4'b1111;
        for (int k = 0; k < 12; k++) tick();
        chk("lock_gnt", 32'(bus.gnt), 32'h2);
        chk("lock_cnt", 32'(bus.owner_cnt), 32'd12);
        bus.lock = 1'b0;
        tick();
        chk_owner("unlock", 2);
        chk("unlock_cnt", 32'(bus.owner_cnt), 32'd0);
`else
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) tick();
        chk_owner("bp_release", 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
